// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the load unit and store-commit unit.
// Optional BUSY watchdog enabled by defining DMEM_ARB_WATCHDOG_EN.
module dmem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        ld_valid_i,
    input  logic [31:0] ld_addr_i,
    output logic        ld_ready_o,
    output logic        ld_resp_valid_o,
    output logic [31:0] ld_resp_data_o,
    input  logic        st_valid_i,
    input  logic [31:0] st_addr_i,
    input  logic [31:0] st_data_i,
    output logic        st_ready_o,
    output logic        st_done_o,
    output logic        dmem_read_o,
    output logic        dmem_write_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_data_o,
    input  logic [31:0] dmem_rd_data_i,
    input  logic        dmem_done_i,
    output logic        arb_error_o
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t state, state_n;
    logic   last_st;     // last grant went to st
    logic   owner_st;    // outstanding transaction belongs to st
    logic   grant_st;
    logic   ld_acc, st_acc, done_busy, drop;

    always_comb begin
        grant_st = 1'b0;
        if (ld_valid_i && st_valid_i) grant_st = ~last_st;
        else if (st_valid_i)          grant_st = 1'b1;
    end

    assign ld_acc    = (state == IDLE) && ld_valid_i && !grant_st;
    assign st_acc    = (state == IDLE) && st_valid_i && grant_st;
    assign done_busy = (state == BUSY) && dmem_done_i;

    // Readys are masked during reset so every output reads 0 while reset_i is high.
    assign ld_ready_o = ld_acc && !reset_i;
    assign st_ready_o = st_acc && !reset_i;

`ifdef DMEM_ARB_WATCHDOG_EN
    logic [TO_W-1:0] wd_cnt;
    logic            err_q;

    assign drop        = (state == BUSY) && !dmem_done_i && (wd_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign arb_error_o = err_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (ld_acc || st_acc)                     wd_cnt <= '0;
            else if ((state == BUSY) && !dmem_done_i) wd_cnt <= wd_cnt + 1'b1;
            if (drop) err_q <= 1'b1;
        end
    end
`else
    logic [TO_W-1:0] wd_unused;
    assign wd_unused   = TO_W'(TIMEOUT_CYCLES);
    assign drop        = 1'b0;
    assign arb_error_o = 1'b0;
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (ld_acc || st_acc)   state_n = BUSY;
            BUSY:    if (done_busy || drop)  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_n;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            dmem_read_o     <= 1'b0;
            dmem_write_o    <= 1'b0;
            dmem_addr_o     <= '0;
            dmem_data_o     <= '0;
            owner_st        <= 1'b0;
            last_st         <= 1'b1;
            ld_resp_valid_o <= 1'b0;
            ld_resp_data_o  <= '0;
            st_done_o       <= 1'b0;
        end else begin
            ld_resp_valid_o <= done_busy && !owner_st;
            st_done_o       <= done_busy && owner_st;
            if (done_busy && !owner_st) ld_resp_data_o <= dmem_rd_data_i;
            if (ld_acc || st_acc) begin
                dmem_read_o  <= ld_acc;
                dmem_write_o <= st_acc;
                dmem_addr_o  <= ld_acc ? ld_addr_i : st_addr_i;
                dmem_data_o  <= st_data_i;
                owner_st     <= st_acc;
                last_st      <= st_acc;
            end else if (done_busy || drop) begin
                dmem_read_o  <= 1'b0;
                dmem_write_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized bench for dmem_port_arbiter against a transaction-level reference model.
module tb_dmem_port_arbiter;
    localparam int T = 8;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        ld_valid_i, st_valid_i, dmem_done_i;
    logic [31:0] ld_addr_i, st_addr_i, st_data_i, dmem_rd_data_i;
    logic        ld_ready_o, ld_resp_valid_o, st_ready_o, st_done_o;
    logic        dmem_read_o, dmem_write_o, arb_error_o;
    logic [31:0] ld_resp_data_o, dmem_addr_o, dmem_data_o;

    always #5 clk_i = ~clk_i;

    dmem_port_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .ld_valid_i(ld_valid_i), .ld_addr_i(ld_addr_i), .ld_ready_o(ld_ready_o),
        .ld_resp_valid_o(ld_resp_valid_o), .ld_resp_data_o(ld_resp_data_o),
        .st_valid_i(st_valid_i), .st_addr_i(st_addr_i), .st_data_i(st_data_i),
        .st_ready_o(st_ready_o), .st_done_o(st_done_o),
        .dmem_read_o(dmem_read_o), .dmem_write_o(dmem_write_o),
        .dmem_addr_o(dmem_addr_o), .dmem_data_o(dmem_data_o),
        .dmem_rd_data_i(dmem_rd_data_i), .dmem_done_i(dmem_done_i),
        .arb_error_o(arb_error_o)
    );

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    // Reference model: one outstanding transaction, round-robin on ties.
    bit          m_busy, m_owner_st, m_last_st, m_ld_resp, m_st_resp, m_err;
    int          m_wd;
    logic [31:0] m_addr, m_data, m_ld_data;
    logic [31:0] model_mem [64];
    bit          ld_acc_f, st_acc_f;

    // Memory responder state (stimulus side).
    logic [31:0] tb_mem [64];
    bit          mem_busy, mem_stall, mem_spur;
    int          mem_cnt, mem_lat;

    bit          seen_ld_rdy, seen_st_rdy;

    task automatic exp_ready(output bit eld, output bit est);
        eld = 0; est = 0;
        if (!m_busy) begin
            if (ld_valid_i && st_valid_i) begin eld = m_last_st; est = !m_last_st; end
            else begin eld = ld_valid_i; est = st_valid_i; end
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_owner_st = 0; m_last_st = 1; m_ld_resp = 0; m_st_resp = 0;
        m_err = 0; m_wd = 0; m_addr = 0; m_data = 0; m_ld_data = 0;
        ld_acc_f = 0; st_acc_f = 0;
        mem_busy = 0; mem_cnt = 0; dmem_done_i = 0;
    endtask

    task automatic model_update();
        bit eld, est;
        exp_ready(eld, est);
        ld_acc_f  = eld;
        st_acc_f  = est;
        m_ld_resp = m_busy && dmem_done_i && !m_owner_st;
        m_st_resp = m_busy && dmem_done_i && m_owner_st;
        if (m_ld_resp) m_ld_data = model_mem[m_addr[7:2]];
        if (m_busy) begin
            if (dmem_done_i) m_busy = 0;
            else begin
                m_wd++;
`ifdef DMEM_ARB_WATCHDOG_EN
                if (m_wd == T) begin m_busy = 0; m_err = 1; end
`endif
            end
        end else if (eld || est) begin
            m_busy = 1; m_owner_st = est; m_last_st = est;
            m_addr = eld ? ld_addr_i : st_addr_i;
            m_data = st_data_i; m_wd = 0;
            if (est) model_mem[st_addr_i[7:2]] = st_data_i;
        end
    endtask

    task automatic mem_respond();
        bit req;
        req = dmem_read_o || dmem_write_o;
        dmem_done_i = 0;
        if (!mem_busy && req && !mem_stall) begin
            mem_busy = 1;
            mem_cnt  = (mem_lat == 0) ? int'($urandom_range(1, 5)) : mem_lat;
        end
        if (mem_busy) begin
            if (mem_cnt <= 1) begin
                dmem_done_i = 1; mem_busy = 0;
                if (dmem_write_o) tb_mem[dmem_addr_o[7:2]] = dmem_data_o;
                else              dmem_rd_data_i = tb_mem[dmem_addr_o[7:2]];
            end else mem_cnt--;
        end else if (!req && mem_spur && $urandom_range(0, 7) == 0) begin
            dmem_done_i = 1; dmem_rd_data_i = $urandom;
        end
    endtask

    task automatic check_outputs();
        bit eld, est;
        exp_ready(eld, est);
        seen_ld_rdy = ld_ready_o;
        seen_st_rdy = st_ready_o;
        chk("ld_ready", 32'(ld_ready_o), 32'(eld));
        chk("st_ready", 32'(st_ready_o), 32'(est));
        chk("dmem_read", 32'(dmem_read_o), 32'(m_busy && !m_owner_st));
        chk("dmem_write", 32'(dmem_write_o), 32'(m_busy && m_owner_st));
        if (m_busy) chk("dmem_addr", dmem_addr_o, m_addr);
        if (m_busy && m_owner_st) chk("dmem_data", dmem_data_o, m_data);
        chk("ld_resp_valid", 32'(ld_resp_valid_o), 32'(m_ld_resp));
        chk("st_done", 32'(st_done_o), 32'(m_st_resp));
        chk("ld_resp_data", ld_resp_data_o, m_ld_data);
        chk("arb_error", 32'(arb_error_o), 32'(m_err));
    endtask

    task automatic cycle();
        @(negedge clk_i) check_outputs();
        @(posedge clk_i) model_update();
        #1 mem_respond();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_out"}, {ld_ready_o, ld_resp_valid_o, st_ready_o, st_done_o,
                           dmem_read_o, dmem_write_o, arb_error_o}, 32'd0);
        chk({tag, "_addr"}, dmem_addr_o, 32'd0);
        chk({tag, "_data"}, dmem_data_o ^ ld_resp_data_o, 32'd0);
    endtask

    task automatic do_reset();
        reset_i = 1;
        #2 check_all_zero("rst");
        ld_valid_i = 0; st_valid_i = 0;
        model_reset();
        @(posedge clk_i);
        #3 reset_i = 0;
    endtask

    initial begin
        int n, pulses;
        reset_i = 0; ld_valid_i = 0; st_valid_i = 0; dmem_done_i = 0;
        ld_addr_i = 0; st_addr_i = 0; st_data_i = 0; dmem_rd_data_i = 0;
        mem_stall = 0; mem_spur = 0; mem_lat = 4;
        for (int i = 0; i < 64; i++) begin
            tb_mem[i] = $urandom; model_mem[i] = tb_mem[i];
        end
        #3;
        do_reset();

        // Single load of a preset word.
        tb_mem[16] = 32'hDEADBEEF; model_mem[16] = 32'hDEADBEEF;
        ld_valid_i = 1; ld_addr_i = 32'h40;
        cycle();
        chk("single_ld_accept", 32'(ld_acc_f), 32'd1);
        ld_valid_i = 0;
        n = 0;
        while (!ld_resp_valid_o && n < 20) begin cycle(); n++; end
        chk("single_ld_resp", 32'(ld_resp_valid_o), 32'd1);
        chk("single_ld_value", ld_resp_data_o, 32'hDEADBEEF);
        cycle(); cycle();

        // Store then load to the same word.
        st_valid_i = 1; st_addr_i = 32'h80; st_data_i = 32'h12345678;
        cycle();
        st_valid_i = 0;
        n = 0;
        while (!st_done_o && n < 20) begin cycle(); n++; end
        chk("st_done_seen", 32'(st_done_o), 32'd1);
        ld_valid_i = 1; ld_addr_i = 32'h80;
        cycle();
        ld_valid_i = 0;
        n = 0;
        while (!ld_resp_valid_o && n < 20) begin cycle(); n++; end
        chk("st_ld_value", ld_resp_data_o, 32'h12345678);
        cycle();

        // Tie from reset: grants alternate ld, st, ld, st.
        do_reset();
        ld_valid_i = 1; ld_addr_i = 32'h10; st_valid_i = 1; st_addr_i = 32'h20; st_data_i = 32'hA5A5A5A5;
        n = 0; pulses = 0;
        while (pulses < 4 && n < 100) begin
            cycle(); n++;
            if (seen_ld_rdy || seen_st_rdy) begin
                chk("tie_grant_st", 32'(seen_st_rdy), 32'(pulses % 2));
                pulses++;
            end
        end
        chk("tie_count", pulses, 4);
        ld_valid_i = 0; st_valid_i = 0;
        repeat (8) cycle();

        // Back-pressure: store arrives while a load is outstanding.
        mem_lat = 5;
        ld_valid_i = 1; ld_addr_i = 32'h44;
        cycle();
        ld_valid_i = 0;
        st_addr_i = 32'h48; st_data_i = 32'h0BADF00D;
        cycle();
        st_valid_i = 1;
        n = 0;
        while (!st_acc_f && n < 20) begin
            cycle(); n++;
            if (!st_acc_f) chk("bp_st_ready_low", 32'(seen_st_rdy), 32'd0);
        end
        chk("bp_st_accepted", 32'(st_acc_f), 32'd1);
        st_valid_i = 0;
        repeat (10) cycle();

        // Reset two cycles after a load accept.
        ld_valid_i = 1; ld_addr_i = 32'h4C;
        cycle();
        ld_valid_i = 0;
        cycle(); cycle();
        #1 do_reset();
        mem_lat = 2;
        pulses = 0;
        repeat (10) begin cycle(); pulses += ld_resp_valid_o; end
        chk("mid_busy_no_resp", pulses, 0);

`ifdef DMEM_ARB_WATCHDOG_EN
        // Memory never answers: watchdog fires and the port recovers.
        mem_stall = 1;
        ld_valid_i = 1; ld_addr_i = 32'h50;
        cycle();
        ld_valid_i = 0;
        n = 0;
        while (!arb_error_o && n < 30) begin cycle(); n++; end
        chk("wd_error", 32'(arb_error_o), 32'd1);
        chk("wd_read_low", 32'(dmem_read_o), 32'd0);
        mem_stall = 0;
        st_valid_i = 1; st_addr_i = 32'h54; st_data_i = 32'hCAFEF00D;
        cycle();
        chk("wd_next_accept", 32'(st_acc_f), 32'd1);
        st_valid_i = 0;
        repeat (8) cycle();
`endif

        // Random traffic with random latency and stray done pulses in IDLE.
        mem_lat = 0; mem_spur = 1;
        repeat (2000) begin
            cycle();
            if (ld_valid_i && ld_acc_f) ld_valid_i = 0;
            if (st_valid_i && st_acc_f) st_valid_i = 0;
            if (!ld_valid_i && $urandom_range(0, 2) == 0) begin
                ld_valid_i = 1; ld_addr_i = 32'($urandom_range(0, 63)) << 2;
            end
            if (!st_valid_i) begin
                st_addr_i = 32'($urandom_range(0, 63)) << 2; st_data_i = $urandom;
                if ($urandom_range(0, 2) == 0) st_valid_i = 1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port (read/write/addr/data in; rd_data/done out) between two requesters in the OoO core: the load unit (ld) and the store-commit unit (st).
- Holds at most one outstanding transaction and drives the memory request signals stable until the memory acknowledges.
- Returns a registered response to whichever requester owns the transaction.
- Sits between the LSU logic inside OoO_top and the top-level dmem_* ports.

Parameters:
- TIMEOUT_CYCLES, 64, watchdog limit in cycles spent in BUSY. Used only when DMEM_ARB_WATCHDOG_EN is defined.
- TO_W, $clog2(TIMEOUT_CYCLES+1), width of the watchdog counter.

Ports:
- clk_i  in  1  core clock
- reset_i  in  1  asynchronous reset, active-high
- ld_valid_i  in  1  load request valid
- ld_addr_i  in  32  load address (word32_t)
- ld_ready_o  out  1  load request accepted this cycle when ld_valid_i is also high
- ld_resp_valid_o  out  1  one-cycle pulse: load data valid
- ld_resp_data_o  out  32  load data (word32_t)
- st_valid_i  in  1  store request valid
- st_addr_i  in  32  store address
- st_data_i  in  32  store data
- st_ready_o  out  1  store request accepted
- st_done_o  out  1  one-cycle pulse: store written
- dmem_read_o  out  1  memory read request
- dmem_write_o  out  1  memory write request
- dmem_addr_o  out  32  memory address
- dmem_data_o  out  32  memory write data
- dmem_rd_data_i  in  32  memory read data, valid when dmem_done_i is high
- dmem_done_i  in  1  one-cycle completion pulse from memory
- arb_error_o  out  1  sticky watchdog error. Tied 0 when the macro is undefined.

Behaviour:
- Clock and reset: one clock, clk_i. reset_i is asynchronous and active-high.
- Reset values: all outputs are 0; state=IDLE; last_grant=ST, so ld wins the first tie; owner=LD.
- FSM:
  - IDLE: compute the grant.
  - BUSY: the memory request is held until dmem_done_i.
- Grant in IDLE, computed combinationally:
  - Only ld_valid_i high: grant ld.
  - Only st_valid_i high: grant st.
  - Both high: grant the requester that is not last_grant (round-robin).
- Ready outputs:
  - ld_ready_o = (state==IDLE) & grant==LD & ld_valid_i. st_ready_o is defined the same way for st.
  - Both readys are 0 in BUSY.
  - A requester must hold valid and its payload stable until it sees ready.
- On accept (IDLE, a ready is high) at clock edge N:
  - Capture addr/data into registers; dmem_addr_o/dmem_data_o come from those registers.
  - Set dmem_read_o (ld) or dmem_write_o (st), owner, last_grant; state goes to BUSY.
  - Result: the memory request is visible from cycle N+1.
- In BUSY: dmem_read_o/dmem_write_o, dmem_addr_o and dmem_data_o stay constant. dmem_data_o is don't-care for reads and is driven from st data anyway.
- On dmem_done_i high in BUSY (cycle D):
  - At edge D, clear dmem_read_o/dmem_write_o and return to IDLE.
  - If owner=LD: ld_resp_data_o <= dmem_rd_data_i and ld_resp_valid_o=1 during cycle D+1.
  - If owner=ST: st_done_o=1 during cycle D+1.
- Response pulses are exactly one cycle. ld_resp_data_o holds its last value until the next load response.
- A new accept may happen in cycle D+1 (IDLE). Its request appears at D+2, so dmem_read_o/dmem_write_o are always low for at least one cycle between transactions.
- dmem_done_i seen in IDLE is ignored: no response, no state change.
- Throughput: one transaction per (memory latency + 2) cycles at most.
- Reset mid-BUSY: the transaction is dropped and no response pulse is generated; the requester is responsible for reissuing.
- dmem_read_o and dmem_write_o are never high together.

Optional Feature:
- Macro: DMEM_ARB_WATCHDOG_EN.
- Defined:
  - A TO_W-bit counter clears on entry to BUSY and increments each BUSY cycle without dmem_done_i.
  - When the counter reaches TIMEOUT_CYCLES: arb_error_o is set (sticky until reset), the request is dropped (read/write low), state returns to IDLE, and no response pulse is generated.
- Undefined: no counter exists, arb_error_o is tied 0, and BUSY waits indefinitely.

Test Plan:
- Single load: after reset, ld_valid_i=1, ld_addr_i=0x40, memory word 0x40 preset to 0xDEADBEEF, memory LATENCY=4 -> ld_ready_o=1 in one cycle; dmem_read_o=1 with addr 0x40 held until done; ld_resp_valid_o one-cycle pulse with data 0xDEADBEEF the cycle after done.
- Store then load: st 0x80 <= 0x12345678, then ld 0x80 -> st_done_o pulse, then ld_resp_data_o=0x12345678; at least one low cycle on both read and write between the two transactions.
- Tie arbitration: ld and st valid together from reset -> ld granted first, then st. Held continuously, the grants alternate ld, st, ld, st over 4 transactions.
- Back-pressure: st_valid_i raised while a load is BUSY -> st_ready_o=0 until IDLE; st_addr_i and st_data_i sampled only at accept; dmem_addr_o unchanged during BUSY.
- Reset mid-BUSY: reset_i asserted two cycles after a load accept -> all outputs 0 asynchronously; no ld_resp_valid_o after reset release.
- Watchdog (macro on, TIMEOUT_CYCLES=8): memory never returns done -> arb_error_o=1 after 8 BUSY cycles; dmem_read_o=0; next request accepted normally.
